mdio_wb_bridge: RTL and testbench

Clause 22 MDIO slave that decodes management frames from an external station manager and turns them into single wishbone cycles on the PHY's internal management bus. It sits directly upstream of the PHY's wishbone management port: its `wb_*` outputs connect one-to-one to the PHY's `wb_*` inputs. MDC/MDIO are oversampled in the PHY's `clk` domain, so no second clock is needed.

---
 rtl/mdio_wb_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_mdio_wb_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_wb_bridge.sv
// Clause 22 MDIO slave that decodes management frames into single wishbone cycles.
// Optional: define MDIO_BROADCAST_EN to also execute write frames addressed to PHY address 0.

module mdio_wb_bridge #(
  parameter logic [4:0] PHYAD         = 5'd0,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [15:0] wb_data_write,
  input  logic [15:0] wb_data_read,
  input  logic        wb_ack,
  input  logic        wb_err
);

  typedef enum logic [2:0] {
    S_PREAMBLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } state_t;

  localparam logic [5:0] PRE_SAT = 6'(PREAMBLE_BITS);

  logic [1:0]  r_mdc_sync;
  logic [1:0]  r_mdio_sync;
  logic        r_mdc_prev;
  logic        w_bit_stb;
  logic        w_bit;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_bit_cnt;
  logic [5:0]  r_ones;
  logic [14:0] r_shift;
  logic        r_is_read;
  logic        r_match;
  logic [4:0]  r_regad;

  logic        r_mdio_o;
  logic        r_mdio_oe;
  logic        r_wb_cyc;
  logic        r_wb_we;
  logic [4:0]  r_wb_addr;
  logic [15:0] r_wb_data;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_rd_pending;

  logic [1:0]  w_op;
  logic [4:0]  w_field5;
  logic        w_match;
  logic        w_serve;
  logic        w_rd_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b00;
      r_mdc_prev  <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      r_mdc_sync  <= {r_mdc_sync[0], mdc};
      r_mdio_sync <= {r_mdio_sync[0], mdio_i};
      r_mdc_prev  <= r_mdc_sync[1];
    end
  end

  assign w_bit_stb = r_mdc_sync[1] & ~r_mdc_prev;
  assign w_bit     = r_mdio_sync[1];
  assign w_op      = {r_shift[0], w_bit};
  assign w_field5  = {r_shift[3:0], w_bit};
  assign w_serve   = r_match;
  assign w_rd_term = r_wb_cyc & (wb_ack | wb_err) & r_rd_pending;

`ifdef MDIO_BROADCAST_EN
  assign w_match = (w_field5 == PHYAD) || (!r_is_read && (w_field5 == 5'd0));
`else
  assign w_match = (w_field5 == PHYAD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_PREAMBLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned and infers a latch.
    w_next_state = r_state;
    if (w_bit_stb) begin
      case (r_state)
        S_PREAMBLE: if (!w_bit && (r_ones == PRE_SAT)) w_next_state = S_ST;
        S_ST:       w_next_state = w_bit ? S_OP : S_PREAMBLE;
        S_OP: begin
          if (r_bit_cnt[0])
            w_next_state = ((w_op == 2'b10) || (w_op == 2'b01)) ? S_PHYAD : S_PREAMBLE;
        end
        S_PHYAD:    if (r_bit_cnt == 4'd4) w_next_state = S_REGAD;
        S_REGAD:    if (r_bit_cnt == 4'd4) w_next_state = S_TA;
        S_TA:       if (r_bit_cnt[0]) w_next_state = S_DATA;
        S_DATA:     if (r_bit_cnt == 4'd15) w_next_state = S_PREAMBLE;
        default:    w_next_state = S_PREAMBLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= 4'd0;
      r_ones       <= 6'd0;
      r_shift      <= 15'd0;
      r_is_read    <= 1'b0;
      r_match      <= 1'b0;
      r_regad      <= 5'd0;
      r_mdio_o     <= 1'b1;
      r_mdio_oe    <= 1'b0;
      r_wb_cyc     <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_addr    <= 5'd0;
      r_wb_data    <= 16'd0;
      r_rd_data    <= 16'hFFFF;
      r_rd_valid   <= 1'b0;
      r_rd_pending <= 1'b0;
    end else begin
      // Termination comes first so that a same-clock frame action can override it.
      if (r_wb_cyc && (wb_ack || wb_err)) begin
        r_wb_cyc <= 1'b0;
        if (r_rd_pending) begin
          r_rd_data    <= wb_err ? 16'hFFFF : wb_data_read;
          r_rd_valid   <= 1'b1;
          r_rd_pending <= 1'b0;
        end
      end

      if (w_bit_stb) begin
        r_shift   <= {r_shift[13:0], w_bit};
        r_bit_cnt <= (w_next_state != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
        if ((r_state == S_PREAMBLE) && w_bit)
          r_ones <= (r_ones == PRE_SAT) ? r_ones : r_ones + 6'd1;
        else
          r_ones <= 6'd0;

        case (r_state)
          S_OP:    if (r_bit_cnt[0]) r_is_read <= (w_op == 2'b10);
          S_PHYAD: if (r_bit_cnt == 4'd4) r_match <= w_match;
          S_REGAD: begin
            if (r_bit_cnt == 4'd4) begin
              r_regad    <= w_field5;
              r_rd_valid <= 1'b0;
              if (r_is_read && w_serve) begin
                if (r_wb_cyc) begin
                  r_rd_data  <= 16'hFFFF;
                  r_rd_valid <= 1'b1;
                end else begin
                  r_wb_cyc     <= 1'b1;
                  r_wb_we      <= 1'b0;
                  r_wb_addr    <= w_field5;
                  r_rd_pending <= 1'b1;
                end
              end
            end
          end
          S_TA: begin
            if (r_is_read && w_serve) begin
              if (!r_bit_cnt[0]) begin
                r_mdio_oe <= 1'b1;
                r_mdio_o  <= 1'b0;
                // Slave too slow: answer all-ones and orphan the outstanding cycle.
                if (!r_rd_valid && !w_rd_term) begin
                  r_rd_data    <= 16'hFFFF;
                  r_rd_valid   <= 1'b1;
                  r_rd_pending <= 1'b0;
                end
              end else begin
                r_mdio_o  <= r_rd_data[15];
                r_rd_data <= {r_rd_data[14:0], 1'b1};
              end
            end
          end
          S_DATA: begin
            if (r_is_read && w_serve) begin
              if (r_bit_cnt == 4'd15) begin
                r_mdio_oe <= 1'b0;
                r_mdio_o  <= 1'b1;
              end else begin
                r_mdio_o  <= r_rd_data[15];
                r_rd_data <= {r_rd_data[14:0], 1'b1};
              end
            end else if (!r_is_read && w_serve && (r_bit_cnt == 4'd15) && !r_wb_cyc) begin
              r_wb_cyc  <= 1'b1;
              r_wb_we   <= 1'b1;
              r_wb_addr <= r_regad;
              r_wb_data <= {r_shift, w_bit};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mdio_o        = r_mdio_o;
  assign mdio_oe       = r_mdio_oe;
  assign wb_cyc        = r_wb_cyc;
  assign wb_stb        = r_wb_cyc;
  assign wb_we         = r_wb_we;
  assign wb_addr       = r_wb_addr;
  assign wb_data_write = r_wb_data;

endmodule

// File: tb/tb_mdio_wb_bridge.sv
// Self-checking bench for mdio_wb_bridge: a station-manager frame driver, a wishbone
// slave model, and scoreboards for expected wishbone cycles and MDIO read words.
`timescale 1ns/1ps

module tb_mdio_wb_bridge;

  localparam logic [4:0] PHY  = 5'd3;
  localparam int         HALF = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        mdc    = 1'b0;
  logic        mdio_i = 1'b1;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data_write;
  logic [15:0] wb_data_read;
  logic        wb_ack;
  logic        wb_err;

  always #4 clk = ~clk;

  mdio_wb_bridge #(.PHYAD(PHY), .PREAMBLE_BITS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mdc           (mdc),
    .mdio_i        (mdio_i),
    .mdio_o        (mdio_o),
    .mdio_oe       (mdio_oe),
    .wb_cyc        (wb_cyc),
    .wb_stb        (wb_stb),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data_write (wb_data_write),
    .wb_data_read  (wb_data_read),
    .wb_ack        (wb_ack),
    .wb_err        (wb_err)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [15:0] rd_q[$];

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          unexpected = 0;
  int          slv_delay  = 2;
  bit          slv_err    = 1'b0;
  logic [15:0] slv_rdata  = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Wishbone slave: compares each new cycle against the scoreboard, then terminates it.
  initial begin
    int      cnt;
    wb_exp_t e;
    cnt          = 0;
    wb_ack       = 1'b0;
    wb_err       = 1'b0;
    wb_data_read = 16'h0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (!wb_cyc) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          check("wb_stb", wb_stb, 1);
          if (wb_q.size() == 0) begin
            unexpected++;
          end else begin
            e = wb_q.pop_front();
            check("wb_we", wb_we, e.we);
            check("wb_addr", wb_addr, e.addr);
            if (e.we) check("wb_wdata", wb_data_write, e.data);
          end
        end
        cnt++;
        if (cnt > slv_delay) begin
          wb_data_read = slv_rdata;
          if (slv_err) wb_err = 1'b1;
          else         wb_ack = 1'b1;
        end
      end
    end
  end

  task automatic expect_wb(input logic we, input logic [4:0] addr, input logic [15:0] data);
    wb_exp_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    wb_q.push_back(e);
  endtask

  // One MDC period; returns the pad state the station sees just before the rising edge.
  task automatic mdc_bit(input logic b, output logic o_s, output logic oe_s);
    mdc    = 1'b0;
    mdio_i = b;
    repeat (HALF) @(posedge clk);
    #1;
    o_s  = mdio_o;
    oe_s = mdio_oe;
    mdc  = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] wdata,
                            input bit expect_drive, input int rst_at);
    logic        o_s, oe_s;
    logic [13:0] hdr;
    logic [15:0] rdata;
    logic [15:0] exp_rd;
    bit          is_read, oe_hdr, oe_tail, ta0_oe, data_oe_all;
    logic [1:0]  ta1;
    is_read     = (op == 2'b10);
    hdr         = {2'b01, op, phy, regad};
    oe_hdr      = 1'b0;
    oe_tail     = 1'b0;
    data_oe_all = 1'b1;
    rdata       = 16'hFFFF;
    for (int i = 0; i < pre; i++) begin
      mdc_bit(1'b1, o_s, oe_s);
      oe_hdr |= oe_s;
    end
    for (int i = 13; i >= 0; i--) begin
      mdc_bit(hdr[i], o_s, oe_s);
      oe_hdr |= oe_s;
    end
    mdc_bit(1'b1, o_s, oe_s);
    ta0_oe = oe_s;
    mdc_bit(is_read ? 1'b1 : 1'b0, o_s, oe_s);
    ta1 = {oe_s, o_s};
    oe_tail = ta0_oe | oe_s;
    for (int i = 15; i >= 0; i--) begin
      mdc_bit(is_read ? 1'b1 : wdata[i], o_s, oe_s);
      rdata[i]     = oe_s ? o_s : 1'b1;
      data_oe_all &= oe_s;
      oe_tail     |= oe_s;
      if (i == rst_at) begin
        mdc   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_frame", {mdio_oe, mdio_o, wb_cyc}, 3'b010);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        return;
      end
    end
    if (expect_drive) begin
      check("hdr_oe", oe_hdr, 0);
      check("ta0_oe", ta0_oe, 0);
      check("ta1_drive", ta1, 2'b10);
      check("data_oe", data_oe_all, 1);
      exp_rd = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hDEAD;
      check("read_data", rdata, exp_rd);
    end else begin
      check("oe_idle", oe_hdr | oe_tail, 0);
    end
    check("post_frame_pad", {mdio_oe, mdio_o}, 2'b01);
    repeat (4) @(posedge clk);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] rdata, input logic [15:0] exp_mdio, input bit served);
    slv_rdata = rdata;
    if (served) begin
      expect_wb(1'b0, regad, 16'h0);
      rd_q.push_back(exp_mdio);
    end
    send_frame(32, 2'b10, phy, regad, 16'h0, served, -1);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] data, input bit served);
    if (served) expect_wb(1'b1, regad, data);
    send_frame(32, 2'b01, phy, regad, data, 1'b0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("rst_mdio_o", mdio_o, 1);
    check("rst_mdio_oe", mdio_oe, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_we", wb_we, 0);
    check("rst_addr", wb_addr, 0);
    check("rst_wdata", wb_data_write, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    slv_delay = 2;
    do_read(PHY, 5'h02, 16'h1234, 16'h1234, 1'b1);
    check("read_cyc_done", wb_cyc, 0);

    slv_delay = 1;
    do_write(PHY, 5'h00, 16'h8000, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("write_cyc_done", wb_cyc, 0);

    do_read(5'd5, 5'h02, 16'h1111, 16'h0, 1'b0);
    do_write(5'd5, 5'h01, 16'hFFFF, 1'b0);
    send_frame(31, 2'b10, PHY, 5'h02, 16'h0, 1'b0, -1);
    send_frame(32, 2'b11, PHY, 5'h02, 16'h0, 1'b0, -1);
    do_read(PHY, 5'h07, 16'hA5C3, 16'hA5C3, 1'b1);

    slv_err = 1'b1;
    do_read(PHY, 5'h04, 16'h4444, 16'hFFFF, 1'b1);
    slv_err = 1'b0;

    slv_delay = 100;
    do_read(PHY, 5'h05, 16'h5555, 16'hFFFF, 1'b1);
    check("late_ack_cyc", wb_cyc, 0);
    slv_delay = 1;

`ifdef MDIO_BROADCAST_EN
    do_write(5'd0, 5'h09, 16'h0BEE, 1'b1);
`else
    do_write(5'd0, 5'h09, 16'h0BEE, 1'b0);
`endif
    do_read(5'd0, 5'h09, 16'h9999, 16'h0, 1'b0);

    slv_delay = 2;
    slv_rdata = 16'h7777;
    expect_wb(1'b0, 5'h01, 16'h0);
    send_frame(32, 2'b10, PHY, 5'h01, 16'h0, 1'b1, 8);
    do_read(PHY, 5'h03, 16'h0F0F, 16'h0F0F, 1'b1);

    slv_delay = 1000;
    do_write(PHY, 5'h06, 16'h1357, 1'b1);
    check("wr_outstanding", wb_cyc, 1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_cycle", {mdio_oe, mdio_o, wb_cyc}, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    slv_delay = 1;
    do_write(PHY, 5'h0A, 16'hCAFE, 1'b1);
    do_read(PHY, 5'h0B, 16'h2468, 16'h2468, 1'b1);

    repeat (20) @(posedge clk);
    #1;
    check("wb_q_empty", wb_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("wb_unexpected", unexpected, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
